// File: rtl/noc_pkg.sv
// Shared NoC definitions: flit type codes, output port codes and the
// switch-allocator request encoding used by the route computation stage.
package noc_pkg;

  localparam logic [1:0] FT_BODY     = 2'b00;
  localparam logic [1:0] FT_TAIL     = 2'b01;
  localparam logic [1:0] FT_HDR      = 2'b10;
  localparam logic [1:0] FT_HDR_TAIL = 2'b11;

  localparam logic [3:0] PORT_NONE = 4'd0;
  localparam logic [3:0] PORT_L    = 4'd1;
  localparam logic [3:0] PORT_E    = 4'd2;
  localparam logic [3:0] PORT_N    = 4'd3;
  localparam logic [3:0] PORT_W    = 4'd4;
  localparam logic [3:0] PORT_S    = 4'd5;

  localparam int REQ_L = 0;
  localparam int REQ_E = 1;
  localparam int REQ_W = 2;
  localparam int REQ_S = 3;
  localparam int REQ_N = 4;

  typedef enum logic {ST_IDLE, ST_LOCKED} rcu_state_e;

  function automatic logic [4:0] port_to_req(input logic [3:0] port);
    logic [4:0] req;
    req = '0;
    case (port)
      PORT_L:  req[REQ_L] = 1'b1;
      PORT_E:  req[REQ_E] = 1'b1;
      PORT_W:  req[REQ_W] = 1'b1;
      PORT_S:  req[REQ_S] = 1'b1;
      PORT_N:  req[REQ_N] = 1'b1;
      default: req = '0;
    endcase
    return req;
  endfunction

endpackage

// File: rtl/route_calc.sv
// Combinational dimension-ordered route selection (XY or YX) for one header
// destination, with out-of-mesh destinations steered to the local port.
module route_calc
  import noc_pkg::*;
#(
  parameter int X_NODES = 4,
  parameter int Y_NODES = 4,
  parameter int X_W     = 2,
  parameter int Y_W     = 2,
  parameter int CUR_X   = 2,
  parameter int CUR_Y   = 3,
  parameter int ROUTING = 0
) (
  input  logic [X_W-1:0] dest_x,
  input  logic [Y_W-1:0] dest_y,
  output logic [3:0]     port,
  output logic           dest_err
);

  localparam logic [X_W:0] CUR_X_EXT = (X_W+1)'(CUR_X);
  localparam logic [Y_W:0] CUR_Y_EXT = (Y_W+1)'(CUR_Y);
  localparam logic [X_W:0] X_LIM     = (X_W+1)'(X_NODES);
  localparam logic [Y_W:0] Y_LIM     = (Y_W+1)'(Y_NODES);

  logic signed [X_W:0] xdiff;
  logic signed [Y_W:0] ydiff;
  logic [3:0] x_port, y_port, first_port, second_port;

  always_comb begin
    // One extra bit keeps the sign of the offset exact for any field value.
    xdiff  = $signed({1'b0, dest_x} - CUR_X_EXT);
    ydiff  = $signed({1'b0, dest_y} - CUR_Y_EXT);
    x_port = (|xdiff) ? (xdiff[X_W] ? PORT_W : PORT_E) : PORT_NONE;
    y_port = (|ydiff) ? (ydiff[Y_W] ? PORT_N : PORT_S) : PORT_NONE;
    first_port  = (ROUTING == 0) ? x_port : y_port;
    second_port = (ROUTING == 0) ? y_port : x_port;
    dest_err = ({1'b0, dest_x} >= X_LIM) || ({1'b0, dest_y} >= Y_LIM);
    if (dest_err)                    port = PORT_L;
    else if (first_port != PORT_NONE)  port = first_port;
    else if (second_port != PORT_NONE) port = second_port;
    else                             port = PORT_L;
  end

endmodule

// File: rtl/route_compute_unit.sv
// Wormhole route-computation stage: routes each header, locks the chosen port
// until the tail leaves, and presents flits through a one-entry output register.
module route_compute_unit
  import noc_pkg::*;
#(
  parameter int X_NODES = 4,
  parameter int Y_NODES = 4,
  parameter int X_W     = 2,
  parameter int Y_W     = 2,
  parameter int CUR_X   = 2,
  parameter int CUR_Y   = 3,
  parameter int FLIT_W  = 34,
  parameter int ROUTING = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [FLIT_W-1:0] in_flit,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [FLIT_W-1:0] out_flit,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [3:0]        out_port,
  output logic [4:0]        out_req,
  output logic              busy,
  output logic              err_seq,
  output logic              err_dest
);

  rcu_state_e state_q, state_d;
  logic [3:0] port_q, port_d;
  logic [3:0] route_port;
  logic       route_err;
  logic [1:0] in_type, out_type;
  logic       accept, leave, release_lock, fwd, seq_err_d, dest_err_d;

  route_calc #(
    .X_NODES(X_NODES), .Y_NODES(Y_NODES), .X_W(X_W), .Y_W(Y_W),
    .CUR_X(CUR_X), .CUR_Y(CUR_Y), .ROUTING(ROUTING)
  ) u_route_calc (
    .dest_x  (in_flit[X_W-1:0]),
    .dest_y  (in_flit[X_W+Y_W-1:X_W]),
    .port    (route_port),
    .dest_err(route_err)
  );

  assign in_type      = in_flit[FLIT_W-1 -: 2];
  assign out_type     = out_flit[FLIT_W-1 -: 2];
  assign in_ready     = !out_valid || out_ready;
  assign accept       = in_valid && in_ready;
  assign leave        = out_valid && out_ready;
  assign release_lock = (state_q == ST_LOCKED) && leave && out_type[0];
  assign out_port     = port_q;
  assign busy         = (state_q == ST_LOCKED);

  // Release is resolved before the incoming flit so a tail and the next
  // header can cross in the same cycle without an idle gap.
  always_comb begin
    state_d    = state_q;
    port_d     = port_q;
    fwd        = 1'b0;
    seq_err_d  = 1'b0;
    dest_err_d = 1'b0;
    if (release_lock) begin
      state_d = ST_IDLE;
      port_d  = PORT_NONE;
    end
    if (accept) begin
      if (in_type[1]) begin
        if (state_d == ST_IDLE) begin
          state_d    = ST_LOCKED;
          port_d     = route_port;
          fwd        = 1'b1;
          dest_err_d = route_err;
        end else begin
          seq_err_d = 1'b1;
        end
      end else if (state_d == ST_LOCKED) begin
        fwd = 1'b1;
      end else begin
        seq_err_d = 1'b1;
      end
    end
  end

  // Output register stage
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      port_q    <= PORT_NONE;
      out_req   <= '0;
      out_valid <= 1'b0;
      out_flit  <= '0;
      err_seq   <= 1'b0;
      err_dest  <= 1'b0;
    end else begin
      state_q  <= state_d;
      port_q   <= port_d;
      out_req  <= port_to_req(port_d);
      err_seq  <= seq_err_d;
      err_dest <= dest_err_d;
      if (fwd) begin
        out_valid <= 1'b1;
        out_flit  <= in_flit;
      end else if (leave) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_route_compute_unit.sv
// Bench for route_compute_unit: directed packet scenarios plus randomized
// traffic against a packet-level reference model, for XY and YX instances.
module tb_route_compute_unit;

  localparam int FW    = 34;
  localparam int CX    = 2;
  localparam int CY    = 3;
  localparam int XN    = 4;
  localparam int YN    = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [FW-1:0] in_flit = '0;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b1;

  logic          in_ready, out_valid, busy, err_seq, err_dest;
  logic [FW-1:0] out_flit;
  logic [3:0]    out_port;
  logic [4:0]    out_req;

  logic          y_in_ready, y_out_valid, y_busy, y_err_seq, y_err_dest;
  logic [FW-1:0] y_out_flit;
  logic [3:0]    y_out_port;
  logic [4:0]    y_out_req;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  route_compute_unit #(.ROUTING(0)) dut (
    .clk(clk), .rst(rst), .in_flit(in_flit), .in_valid(in_valid), .in_ready(in_ready),
    .out_flit(out_flit), .out_valid(out_valid), .out_ready(out_ready),
    .out_port(out_port), .out_req(out_req), .busy(busy),
    .err_seq(err_seq), .err_dest(err_dest)
  );

  route_compute_unit #(.ROUTING(1)) dut_yx (
    .clk(clk), .rst(rst), .in_flit(in_flit), .in_valid(in_valid), .in_ready(y_in_ready),
    .out_flit(y_out_flit), .out_valid(y_out_valid), .out_ready(out_ready),
    .out_port(y_out_port), .out_req(y_out_req), .busy(y_busy),
    .err_seq(y_err_seq), .err_dest(y_err_dest)
  );

  // ---------------- reference model ----------------
  function automatic int route_of(input int x, input int y, input int yx_first);
    int dx, dy, xp, yp;
    if (x >= XN || y >= YN) return 1;
    dx = x - CX;
    dy = y - CY;
    xp = (dx > 0) ? 2 : (dx < 0) ? 4 : 0;
    yp = (dy > 0) ? 5 : (dy < 0) ? 3 : 0;
    if (yx_first != 0) return (yp != 0) ? yp : (xp != 0) ? xp : 1;
    return (xp != 0) ? xp : (yp != 0) ? yp : 1;
  endfunction

  function automatic logic [4:0] req_of(input int p);
    case (p)
      1: return 5'b00001;
      2: return 5'b00010;
      4: return 5'b00100;
      5: return 5'b01000;
      3: return 5'b10000;
      default: return 5'b00000;
    endcase
  endfunction

  function automatic logic [FW-1:0] mk(input logic [1:0] t, input int x, input int y);
    logic [27:0] pay;
    pay = 28'($urandom);
    return {t, pay, 2'(y), 2'(x)};
  endfunction

  logic          m_valid = 0, m_lock = 0, m_eseq = 0, m_edest = 0;
  logic [FW-1:0] m_flit = '0;
  int            m_pxy = 0, m_pyx = 0;
  logic          n_valid, n_lock, n_eseq, n_edest, n_fw, n_leave;
  logic [FW-1:0] n_flit;
  int            n_pxy, n_pyx;

  always @* begin
    n_valid = m_valid; n_lock = m_lock; n_flit = m_flit;
    n_pxy = m_pxy; n_pyx = m_pyx; n_eseq = 0; n_edest = 0; n_fw = 0;
    n_leave = m_valid && out_ready;
    if (n_leave && m_flit[FW-2] && m_lock) begin
      n_lock = 0; n_pxy = 0; n_pyx = 0;
    end
    if (in_valid && (!m_valid || out_ready)) begin
      if (in_flit[FW-1]) begin
        if (!n_lock) begin
          n_lock  = 1; n_fw = 1;
          n_pxy   = route_of(int'(in_flit[1:0]), int'(in_flit[3:2]), 0);
          n_pyx   = route_of(int'(in_flit[1:0]), int'(in_flit[3:2]), 1);
          n_edest = (int'(in_flit[1:0]) >= XN) || (int'(in_flit[3:2]) >= YN);
        end else n_eseq = 1;
      end else if (n_lock) n_fw = 1;
      else n_eseq = 1;
    end
    if (n_fw) begin n_valid = 1; n_flit = in_flit; end
    else if (n_leave) n_valid = 0;
  end

  always @(posedge clk) begin
    if (rst) begin
      m_valid <= 0; m_lock <= 0; m_eseq <= 0; m_edest <= 0;
      m_flit <= '0; m_pxy <= 0; m_pyx <= 0;
    end else begin
      m_valid <= n_valid; m_lock <= n_lock; m_eseq <= n_eseq; m_edest <= n_edest;
      m_flit <= n_flit; m_pxy <= n_pxy; m_pyx <= n_pyx;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1; in_valid = 0; out_ready = 1;
    tick(); tick();
    rst = 0;
    n_checks++;
    if ({out_valid, out_port, out_req, busy, err_seq, err_dest, in_ready} !== {1'b0, 4'd0, 5'd0, 3'b000, 1'b1}
        || out_flit !== '0) begin
      n_err++;
      $display("FAIL reset: valid=%b port=%0d req=%b busy=%b eseq=%b edest=%b rdy=%b flit=%h, required all zero with in_ready=1",
               out_valid, out_port, out_req, busy, err_seq, err_dest, in_ready, out_flit);
    end
  endtask

  task automatic test_xy_packet();
    logic [FW-1:0] h, b, t;
    h = mk(2'b10, 0, 3); b = mk(2'b00, 1, 1); t = mk(2'b01, 3, 3);
    out_ready = 1; in_valid = 1; in_flit = h;
    tick();
    n_checks++;
    if (out_valid !== 1 || out_flit !== h || out_port !== 4'd4 || out_req !== 5'b00100 || busy !== 1) begin
      n_err++;
      $display("FAIL xy_hdr: valid=%b port=%0d req=%b busy=%b, required 1/4/00100/1", out_valid, out_port, out_req, busy);
    end
    in_flit = b;
    tick();
    n_checks++;
    if (out_flit !== b || out_port !== 4'd4 || out_req !== 5'b00100) begin
      n_err++;
      $display("FAIL xy_body: flit=%h port=%0d req=%b, required %h/4/00100", out_flit, out_port, out_req, b);
    end
    in_flit = t;
    tick();
    n_checks++;
    if (out_flit !== t || out_port !== 4'd4 || busy !== 1) begin
      n_err++;
      $display("FAIL xy_tail: flit=%h port=%0d busy=%b, required %h/4/1", out_flit, out_port, busy, t);
    end
    in_valid = 0;
    tick();
    n_checks++;
    if (busy !== 0 || out_valid !== 0 || out_port !== 4'd0 || out_req !== 5'd0) begin
      n_err++;
      $display("FAIL xy_release: busy=%b valid=%b port=%0d req=%b, required 0/0/0/0", busy, out_valid, out_port, out_req);
    end
  endtask

  task automatic test_routes();
    out_ready = 1; in_valid = 1; in_flit = mk(2'b10, 3, 1);
    tick();
    n_checks++;
    if (out_port !== 4'd2 || out_req !== 5'b00010) begin
      n_err++;
      $display("FAIL route_xy: port=%0d req=%b, required 2/00010", out_port, out_req);
    end
    n_checks++;
    if (y_out_port !== 4'd3 || y_out_req !== 5'b10000) begin
      n_err++;
      $display("FAIL route_yx: port=%0d req=%b, required 3/10000", y_out_port, y_out_req);
    end
    in_flit = mk(2'b01, 0, 0);
    tick();
    in_valid = 0;
    tick();
  endtask

  task automatic test_hdr_tail_stall();
    logic [FW-1:0] ht;
    ht = mk(2'b11, 2, 3);
    out_ready = 0; in_valid = 1; in_flit = ht;
    tick();
    in_valid = 0; in_flit = mk(2'b10, 0, 0);
    n_checks++;
    if (out_port !== 4'd1 || out_req !== 5'b00001 || busy !== 1 || out_valid !== 1) begin
      n_err++;
      $display("FAIL ht_route: port=%0d req=%b busy=%b valid=%b, required 1/00001/1/1", out_port, out_req, busy, out_valid);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if (out_flit !== ht || out_valid !== 1 || in_ready !== 0 || busy !== 1) begin
        n_err++;
        $display("FAIL ht_stall%0d: flit=%h valid=%b rdy=%b busy=%b, required %h/1/0/1", i, out_flit, out_valid, in_ready, busy, ht);
      end
    end
    out_ready = 1;
    tick();
    n_checks++;
    if (busy !== 0 || out_valid !== 0 || out_port !== 4'd0) begin
      n_err++;
      $display("FAIL ht_release: busy=%b valid=%b port=%0d, required 0/0/0", busy, out_valid, out_port);
    end
  endtask

  task automatic test_back_to_back();
    logic [FW-1:0] h2;
    h2 = mk(2'b10, 2, 0);
    out_ready = 1; in_valid = 1; in_flit = mk(2'b10, 0, 3);
    tick();
    in_flit = mk(2'b01, 1, 2);
    tick();
    in_flit = h2;
    tick();
    n_checks++;
    if (out_valid !== 1 || out_flit !== h2 || out_port !== 4'd3 || out_req !== 5'b10000 || busy !== 1) begin
      n_err++;
      $display("FAIL b2b: valid=%b port=%0d req=%b busy=%b flit=%h, required 1/3/10000/1/%h",
               out_valid, out_port, out_req, busy, out_flit, h2);
    end
    in_flit = mk(2'b01, 0, 0);
    tick();
    in_valid = 0;
    tick();
  endtask

  task automatic test_err_seq();
    out_ready = 1; in_valid = 1; in_flit = mk(2'b00, 1, 1);
    tick();
    in_valid = 0;
    n_checks++;
    if (err_seq !== 1 || out_valid !== 0 || busy !== 0) begin
      n_err++;
      $display("FAIL seq_idle: eseq=%b valid=%b busy=%b, required 1/0/0", err_seq, out_valid, busy);
    end
    tick();
    n_checks++;
    if (err_seq !== 0) begin
      n_err++;
      $display("FAIL seq_pulse: eseq=%b, required 0", err_seq);
    end
    in_valid = 1; in_flit = mk(2'b10, 0, 3);
    tick();
    in_flit = mk(2'b10, 3, 1);
    tick();
    in_valid = 0;
    n_checks++;
    if (err_seq !== 1 || out_port !== 4'd4 || busy !== 1 || out_valid !== 0) begin
      n_err++;
      $display("FAIL seq_locked: eseq=%b port=%0d busy=%b valid=%b, required 1/4/1/0", err_seq, out_port, busy, out_valid);
    end
    in_valid = 1; in_flit = mk(2'b01, 0, 0);
    tick();
    in_valid = 0;
    tick();
  endtask

  task automatic test_reset_mid();
    out_ready = 0; in_valid = 1; in_flit = mk(2'b10, 0, 3);
    tick();
    in_valid = 0; rst = 1;
    tick();
    rst = 0;
    n_checks++;
    if ({out_valid, out_port, out_req, busy, err_seq, err_dest} !== 13'd0 || out_flit !== '0) begin
      n_err++;
      $display("FAIL reset_mid: valid=%b port=%0d req=%b busy=%b eseq=%b edest=%b flit=%h, required all zero",
               out_valid, out_port, out_req, busy, err_seq, err_dest, out_flit);
    end
    out_ready = 1; in_valid = 1; in_flit = mk(2'b00, 1, 1);
    tick();
    in_valid = 0;
    n_checks++;
    if (err_seq !== 1 || out_valid !== 0) begin
      n_err++;
      $display("FAIL reset_body: eseq=%b valid=%b, required 1/0", err_seq, out_valid);
    end
    tick();
  endtask

  task automatic test_random();
    int r;
    logic [1:0] t;
    for (int i = 0; i < 400; i++) begin
      r = int'($urandom_range(99));
      t = (r < 30) ? 2'b10 : (r < 45) ? 2'b11 : (r < 80) ? 2'b00 : 2'b01;
      in_flit   = mk(t, int'($urandom_range(3)), int'($urandom_range(3)));
      in_valid  = ($urandom_range(99) < 70);
      out_ready = ($urandom_range(99) < 65);
      tick();
      n_checks++;
      if (out_valid !== m_valid || out_flit !== m_flit || out_port !== 4'(m_pxy) || out_req !== req_of(m_pxy)
          || busy !== m_lock || err_seq !== m_eseq || err_dest !== m_edest || in_ready !== (!m_valid || out_ready)) begin
        n_err++;
        $display("FAIL rand_xy[%0d]: valid=%b port=%0d req=%b busy=%b eseq=%b edest=%b rdy=%b, required %b/%0d/%b/%b/%b/%b/%b",
                 i, out_valid, out_port, out_req, busy, err_seq, err_dest, in_ready,
                 m_valid, m_pxy, req_of(m_pxy), m_lock, m_eseq, m_edest, (!m_valid || out_ready));
      end
      n_checks++;
      if (y_out_valid !== m_valid || y_out_flit !== m_flit || y_out_port !== 4'(m_pyx) || y_out_req !== req_of(m_pyx)
          || y_busy !== m_lock || y_err_seq !== m_eseq || y_err_dest !== m_edest || y_in_ready !== (!m_valid || out_ready)) begin
        n_err++;
        $display("FAIL rand_yx[%0d]: valid=%b port=%0d req=%b busy=%b eseq=%b edest=%b, required %b/%0d/%b/%b/%b/%b",
                 i, y_out_valid, y_out_port, y_out_req, y_busy, y_err_seq, y_err_dest,
                 m_valid, m_pyx, req_of(m_pyx), m_lock, m_eseq, m_edest);
      end
    end
    in_valid = 0; out_ready = 1;
    tick(); tick();
  endtask

  initial begin
    test_reset();
    test_xy_packet();
    test_routes();
    test_hdr_tail_stall();
    test_back_to_back();
    test_err_seq();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
